// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF synchroniser, run-time baud divisor, majority-vote
// mid-bit sampling, false-start rejection, parity/framing flags and valid/ready delivery.
module uart_rx_cfg #(
   parameter int CLOCK       = 100000000,
   parameter int BAUDRATE    = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int OVERSAMPLE  = 16
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 rx_pin,
   input  logic [15:0]          baud_div,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int              DEF_DIV_I = CLOCK / (BAUDRATE * OVERSAMPLE);
   localparam logic [15:0]     DEF_DIV   = (DEF_DIV_I < 1) ? 16'd1 : 16'(DEF_DIV_I);
   localparam int              SW        = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0]   S_LAST    = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0]   S_M0      = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0]   S_M1      = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0]   S_M2      = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   function automatic logic maj3_f(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic par_err_f(input logic [DATA_BITS-1:0] d, input logic p);
      case (PARITY_MODE)
         1:       return (^d) ^ p;
         2:       return ~((^d) ^ p);
         default: return 1'b0;
      endcase
   endfunction

   logic [1:0]           sync_r;
   logic                 rxs_s;
   logic [15:0]          cnt_r, div_r, div_s;
   logic                 tick_s;
   state_t               state_r, state_n;
   logic [SW-1:0]        s_r, s_n;
   logic [3:0]           bit_r, bit_n;
   logic                 stop_r, stop_n;
   logic [1:0]           smp_r, smp_n;
   logic [DATA_BITS-1:0] shreg_r, shreg_n;
   logic                 perr_r, perr_n, ferr_r, ferr_n;
   logic                 maj_s, done_s;

   assign rxs_s = sync_r[1];

   // Effective divisor follows baud_div only while idle, otherwise the latched copy
   always_comb begin
      div_s = div_r;
      if (state_r == IDLE) begin
         div_s = (baud_div == 16'd0) ? DEF_DIV : baud_div;
      end else begin
         div_s = div_r;
      end
      tick_s = (cnt_r >= (div_s - 16'd1));
   end

   // Next-state and datapath update, all qualified by the sample tick
   always_comb begin
      state_n = state_r;
      s_n     = s_r;
      bit_n   = bit_r;
      stop_n  = stop_r;
      smp_n   = smp_r;
      shreg_n = shreg_r;
      perr_n  = perr_r;
      ferr_n  = ferr_r;
      done_s  = 1'b0;
      maj_s   = maj3_f(smp_r[0], smp_r[1], rxs_s);
      if (tick_s) begin
         if (s_r == S_M0) begin
            smp_n[0] = rxs_s;
         end else if (s_r == S_M1) begin
            smp_n[1] = rxs_s;
         end else begin
            smp_n = smp_r;
         end
         s_n = (s_r == S_LAST) ? {SW{1'b0}} : s_r + SW'(1);
         case (state_r)
            IDLE: begin
               if (!rxs_s) begin
                  state_n = START;
                  s_n     = SW'(1);
                  bit_n   = 4'd0;
                  stop_n  = 1'b0;
                  perr_n  = 1'b0;
                  ferr_n  = 1'b0;
               end else begin
                  s_n = {SW{1'b0}};
               end
            end
            START: begin
               if ((s_r == S_M2) && maj_s) begin
                  state_n = IDLE;
               end else if (s_r == S_LAST) begin
                  state_n = DATA;
               end else begin
                  state_n = START;
               end
            end
            DATA: begin
               if (s_r == S_M2) begin
                  shreg_n = {maj_s, shreg_r[DATA_BITS-1:1]};
               end else if (s_r == S_LAST) begin
                  if (bit_r == BIT_LAST) begin
                     bit_n = 4'd0;
                     if (PARITY_MODE != 0) begin
                        state_n = PARITY;
                     end else begin
                        state_n = STOP;
                     end
                  end else begin
                     bit_n = bit_r + 4'd1;
                  end
               end else begin
                  shreg_n = shreg_r;
               end
            end
            PARITY: begin
               if (s_r == S_M2) begin
                  perr_n = par_err_f(shreg_r, maj_s);
               end else if (s_r == S_LAST) begin
                  state_n = STOP;
               end else begin
                  perr_n = perr_r;
               end
            end
            STOP: begin
               // The last stop bit completes at its mid-bit vote so the next start edge is not missed
               if (s_r == S_M2) begin
                  ferr_n = ferr_r | ~maj_s;
                  if (stop_r == STOP_LAST) begin
                     done_s = 1'b1;
                     if (ferr_r | ~maj_s) begin
                        state_n = WAIT_HIGH;
                     end else begin
                        state_n = IDLE;
                     end
                  end else begin
                     state_n = STOP;
                  end
               end else if (s_r == S_LAST) begin
                  stop_n = stop_r + 1'b1;
               end else begin
                  stop_n = stop_r;
               end
            end
            WAIT_HIGH: begin
               if (rxs_s) begin
                  state_n = IDLE;
               end else begin
                  state_n = WAIT_HIGH;
               end
            end
            default: state_n = IDLE;
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // Synchroniser, tick counter, FSM state and frame datapath registers
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         sync_r  <= 2'b11;
         cnt_r   <= 16'd0;
         div_r   <= DEF_DIV;
         state_r <= IDLE;
         s_r     <= {SW{1'b0}};
         bit_r   <= 4'd0;
         stop_r  <= 1'b0;
         smp_r   <= 2'b11;
         shreg_r <= {DATA_BITS{1'b0}};
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], rx_pin};
         cnt_r   <= tick_s ? 16'd0 : cnt_r + 16'd1;
         div_r   <= div_s;
         state_r <= state_n;
         s_r     <= s_n;
         bit_r   <= bit_n;
         stop_r  <= stop_n;
         smp_r   <= smp_n;
         shreg_r <= shreg_n;
         perr_r  <= perr_n;
         ferr_r  <= ferr_n;
      end
   end

   // Delivery: accept-and-complete in the same cycle loads the new word rather than overrunning
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         rx_data     <= {DATA_BITS{1'b0}};
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         busy        <= (state_n != IDLE);
         if (done_s) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shreg_r;
               parity_err <= perr_r;
               frame_err  <= ferr_n;
               rx_valid   <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end else begin
            rx_valid <= rx_valid;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1 default, 8E1, 7N2) driven
// with hand-built frames; delivered words are captured at the handshake.
module tb_uart_rx_cfg;

   typedef struct {
      logic [7:0] data;
      logic       pbit;
      logic       stopv;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic [15:0] baud_div0 = 16'd0, baud_div1 = 16'd4, baud_div2 = 16'd8;
   logic        rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
   logic [7:0]  rx_data0, rx_data1;
   logic [6:0]  rx_data2;
   logic        rx_valid0, rx_valid1, rx_valid2;
   logic        parity_err0, parity_err1, parity_err2;
   logic        frame_err0, frame_err1, frame_err2;
   logic        overrun_err0, overrun_err1, overrun_err2;
   logic        busy0, busy1, busy2;

   int n_vec = 0;
   int n_err = 0;
   int cnt0 = 0, cnt1 = 0, cnt2 = 0, ovr0 = 0;
   logic [7:0] last0 = 8'd0, last1 = 8'd0, last2 = 8'd0;
   logic lperr0 = 1'b0, lferr0 = 1'b0, lperr1 = 1'b0, lferr1 = 1'b0, lferr2 = 1'b0;

   always #5 clk = ~clk;

   uart_rx_cfg u0 (
      .clk(clk), .n_reset(n_reset), .rx_pin(rx0), .baud_div(baud_div0),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rdy0),
      .parity_err(parity_err0), .frame_err(frame_err0), .overrun_err(overrun_err0), .busy(busy0)
   );

   uart_rx_cfg #(.PARITY_MODE(1)) u1 (
      .clk(clk), .n_reset(n_reset), .rx_pin(rx1), .baud_div(baud_div1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rdy1),
      .parity_err(parity_err1), .frame_err(frame_err1), .overrun_err(overrun_err1), .busy(busy1)
   );

   uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
      .clk(clk), .n_reset(n_reset), .rx_pin(rx2), .baud_div(baud_div2),
      .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rdy2),
      .parity_err(parity_err2), .frame_err(frame_err2), .overrun_err(overrun_err2), .busy(busy2)
   );

   // Capture handshakes and overrun pulses with the same pre-edge view the DUT uses
   always @(posedge clk) begin
      if (rx_valid0 && rdy0) begin
         cnt0 <= cnt0 + 1; last0 <= rx_data0; lperr0 <= parity_err0; lferr0 <= frame_err0;
      end
      if (overrun_err0) ovr0 <= ovr0 + 1;
      if (rx_valid1 && rdy1) begin
         cnt1 <= cnt1 + 1; last1 <= rx_data1; lperr1 <= parity_err1; lferr1 <= frame_err1;
      end
      if (rx_valid2 && rdy2) begin
         cnt2 <= cnt2 + 1; last2 <= {1'b0, rx_data2}; lferr2 <= frame_err2;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int sel, input logic v);
      case (sel)
         0:       rx0 = v;
         1:       rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   task automatic send(input int sel, input logic [8:0] data, input int nbits, input bit has_par,
                       input logic pbit, input int nstop, input logic stopv, input int div,
                       input logic tailv, input int tailbits);
      int bp;
      bp = div * 16;
      drive(sel, 1'b0); wait_clk(bp);
      for (int i = 0; i < nbits; i++) begin
         drive(sel, data[i]); wait_clk(bp);
      end
      if (has_par) begin
         drive(sel, pbit); wait_clk(bp);
      end
      for (int i = 0; i < nstop; i++) begin
         drive(sel, stopv); wait_clk(bp);
      end
      drive(sel, tailv); wait_clk(bp * tailbits);
   endtask

   vec_t tbl [6];
   int   c;

   initial begin
      tbl[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};

      wait_clk(5);
      n_reset = 1'b1;
      wait_clk(1);
      chk("reset_valid", {31'd0, rx_valid0}, 32'd0);
      chk("reset_busy", {31'd0, busy0}, 32'd0);
      chk("reset_data", {24'd0, rx_data0}, 32'd0);
      chk("reset_overrun", {31'd0, overrun_err0}, 32'd0);

      // Default divisor 54 -> 864 clocks per bit
      c = cnt0;
      send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 54, 1'b1, 2);
      chk("a5_count", cnt0, c + 1);
      chk("a5_data", {24'd0, last0}, 32'hA5);
      chk("a5_perr", {31'd0, lperr0}, 32'd0);
      chk("a5_ferr", {31'd0, lferr0}, 32'd0);
      chk("a5_valid_pulse", {31'd0, rx_valid0}, 32'd0);
      chk("a5_busy", {31'd0, busy0}, 32'd0);

      baud_div0 = 16'd4;
      wait_clk(128);

      // Two-tick low glitch must be rejected as a false start
      c = cnt0;
      rx0 = 1'b0; wait_clk(8);
      rx0 = 1'b1; wait_clk(16);
      chk("glitch_busy_hi", {31'd0, busy0}, 32'd1);
      wait_clk(64);
      chk("glitch_busy_lo", {31'd0, busy0}, 32'd0);
      chk("glitch_no_word", cnt0, c);
      send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 4, 1'b1, 2);
      chk("5a_count", cnt0, c + 1);
      chk("5a_data", {24'd0, last0}, 32'h5A);

      // Framing error followed by 20 low bit times
      c = cnt0;
      send(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b0, 4, 1'b0, 20);
      chk("7e_count", cnt0, c + 1);
      chk("7e_data", {24'd0, last0}, 32'h7E);
      chk("7e_ferr", {31'd0, lferr0}, 32'd1);
      chk("7e_wait_busy", {31'd0, busy0}, 32'd1);
      rx0 = 1'b1; wait_clk(128);
      chk("7e_released", {31'd0, busy0}, 32'd0);
      chk("7e_no_extra", cnt0, c + 1);

      // Overrun: second frame dropped while first is held
      rdy0 = 1'b0;
      c = ovr0;
      send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 4, 1'b1, 2);
      chk("ovr_first_valid", {31'd0, rx_valid0}, 32'd1);
      chk("ovr_first_data", {24'd0, rx_data0}, 32'h11);
      send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 4, 1'b1, 2);
      chk("ovr_pulses", ovr0, c + 1);
      chk("ovr_data_kept", {24'd0, rx_data0}, 32'h11);
      c = cnt0;
      rdy0 = 1'b1;
      wait_clk(2);
      chk("ovr_accept_count", cnt0, c + 1);
      chk("ovr_accept_data", {24'd0, last0}, 32'h11);
      chk("ovr_valid_drop", {31'd0, rx_valid0}, 32'd0);

      // Even-parity table on u1
      for (int i = 0; i < 6; i++) begin
         c = cnt1;
         send(1, {1'b0, tbl[i].data}, 8, 1'b1, tbl[i].pbit, 1, tbl[i].stopv, 4, 1'b1, 2);
         chk($sformatf("par%0d_count", i), cnt1, c + 1);
         chk($sformatf("par%0d_data", i), {24'd0, last1}, {24'd0, tbl[i].data});
         chk($sformatf("par%0d_perr", i), {31'd0, lperr1}, {31'd0, tbl[i].exp_perr});
         chk($sformatf("par%0d_ferr", i), {31'd0, lferr1}, {31'd0, tbl[i].exp_ferr});
      end

      // 7N2 at divisor 8, then reset mid-frame with a word pending
      rdy2 = 1'b0;
      send(2, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1, 8, 1'b1, 2);
      chk("u2_valid", {31'd0, rx_valid2}, 32'd1);
      chk("u2_data", {25'd0, rx_data2}, 32'h55);
      rx2 = 1'b0; wait_clk(384);
      chk("u2_mid_busy", {31'd0, busy2}, 32'd1);
      rx2 = 1'b1;
      n_reset = 1'b0;
      wait_clk(2);
      chk("rst_valid", {31'd0, rx_valid2}, 32'd0);
      chk("rst_data", {25'd0, rx_data2}, 32'd0);
      chk("rst_busy", {31'd0, busy2}, 32'd0);
      n_reset = 1'b1;
      rdy2 = 1'b1;
      wait_clk(256);
      c = cnt2;
      send(2, 9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, 8, 1'b1, 2);
      chk("u2_after_rst_count", cnt2, c + 1);
      chk("u2_after_rst_data", {24'd0, last2}, 32'h2A);
      chk("u2_after_rst_ferr", {31'd0, lferr2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
